// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, sync polarity constants, 12-bit colour type and
// test-pattern colours used by the raster timing generator.
package vga_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FRONT_DEF  = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BACK_DEF   = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FRONT_DEF  = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BACK_DEF   = 33;

  localparam logic POL_LOW  = 1'b0;
  localparam logic POL_HIGH = 1'b1;

  typedef logic [11:0] rgb12;

  typedef enum logic [1:0] {
    PAT_BARS    = 2'd0,
    PAT_CHECKER = 2'd1,
    PAT_RAMP    = 2'd2,
    PAT_SOLID   = 2'd3
  } pat_e;

  localparam rgb12 RGB_WHITE   = 12'hFFF;
  localparam rgb12 RGB_YELLOW  = 12'hFF0;
  localparam rgb12 RGB_CYAN    = 12'h0FF;
  localparam rgb12 RGB_GREEN   = 12'h0F0;
  localparam rgb12 RGB_MAGENTA = 12'hF0F;
  localparam rgb12 RGB_RED     = 12'hF00;
  localparam rgb12 RGB_BLUE    = 12'h00F;
  localparam rgb12 RGB_BLACK   = 12'h000;

  // Colour-bar order, left to right across the active line.
  function automatic rgb12 bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    return RGB_WHITE;
      3'd1:    return RGB_YELLOW;
      3'd2:    return RGB_CYAN;
      3'd3:    return RGB_GREEN;
      3'd4:    return RGB_MAGENTA;
      3'd5:    return RGB_RED;
      3'd6:    return RGB_BLUE;
      default: return RGB_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/vga_pix_tick.sv
// Pixel clock-enable divider: one p_tick every CLK_DIV enabled clk_50MHz cycles.
// adv_o is the unregistered advance condition the counters use on the same edge.
module vga_pix_tick #(
  parameter int CLK_DIV = 2
) (
  input  logic clk_50MHz,
  input  logic rst,
  input  logic en_i,
  output logic adv_o,
  output logic p_tick_o
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_q, div_d;
  logic          p_tick_q;

  assign adv_o = en_i && (div_q == DIV_LAST);

  always_comb begin
    div_d = div_q;
    if (en_i) div_d = adv_o ? '0 : div_q + DW'(1);
  end

  always_ff @(posedge clk_50MHz or posedge rst) begin
    if (rst) begin
      div_q    <= '0;
      p_tick_q <= 1'b0;
    end else begin
      div_q    <= div_d;
      p_tick_q <= adv_o;
    end
  end

  assign p_tick_o = p_tick_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: x/y counters, syncs, blanking and strobes.
// Define VGA_TIMING_TESTPAT_EN to add pat_sel_i / rgb_o built-in test patterns.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE = H_ACTIVE_DEF,
  parameter int   H_FRONT  = H_FRONT_DEF,
  parameter int   H_SYNC   = H_SYNC_DEF,
  parameter int   H_BACK   = H_BACK_DEF,
  parameter int   V_ACTIVE = V_ACTIVE_DEF,
  parameter int   V_FRONT  = V_FRONT_DEF,
  parameter int   V_SYNC   = V_SYNC_DEF,
  parameter int   V_BACK   = V_BACK_DEF,
  parameter int   CLK_DIV  = 2,
  parameter logic HS_POL   = POL_LOW,
  parameter logic VS_POL   = POL_LOW,
  parameter int   CW       = 11
) (
  input  logic          clk_50MHz,
  input  logic          rst,
  input  logic          en_i,
`ifdef VGA_TIMING_TESTPAT_EN
  input  logic [1:0]    pat_sel_i,
  output rgb12          rgb_o,
`endif
  output logic          p_tick_o,
  output logic          video_on_o,
  output logic          hsync_o,
  output logic          vsync_o,
  output logic [CW-1:0] x_o,
  output logic [CW-1:0] y_o,
  output logic          line_start_o,
  output logic          frame_start_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FRONT);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FRONT);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FRONT + V_SYNC);

  logic          adv;
  logic [CW-1:0] x_q, x_d, y_q, y_d;
  logic          video_on_q, video_on_d;
  logic          hsync_q, hsync_d, vsync_q, vsync_d;
  logic          line_start_q, line_start_d, frame_start_q, frame_start_d;

  vga_pix_tick #(.CLK_DIV(CLK_DIV)) u_pix_tick (
    .clk_50MHz (clk_50MHz),
    .rst       (rst),
    .en_i      (en_i),
    .adv_o     (adv),
    .p_tick_o  (p_tick_o)
  );

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (adv) begin
      if (x_q == H_LAST) begin
        x_d = '0;
        y_d = (y_q == V_LAST) ? '0 : y_q + CW'(1);
      end else begin
        x_d = x_q + CW'(1);
      end
    end
  end

  // Decode from the next counts so every output moves on the same edge as x/y.
  always_comb begin
    video_on_d    = (x_d < H_ACT) && (y_d < V_ACT);
    hsync_d       = ((x_d >= HS_START) && (x_d < HS_END)) ? HS_POL : ~HS_POL;
    vsync_d       = ((y_d >= VS_START) && (y_d < VS_END)) ? VS_POL : ~VS_POL;
    line_start_d  = adv && (x_d == '0);
    frame_start_d = adv && (x_d == '0) && (y_d == '0);
  end

  always_ff @(posedge clk_50MHz or posedge rst) begin
    if (rst) begin
      x_q           <= H_LAST;
      y_q           <= V_LAST;
      video_on_q    <= 1'b0;
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      video_on_q    <= video_on_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign x_o           = x_q;
  assign y_o           = y_q;
  assign video_on_o    = video_on_q;
  assign hsync_o       = hsync_q;
  assign vsync_o       = vsync_q;
  assign line_start_o  = line_start_q;
  assign frame_start_o = frame_start_q;

`ifdef VGA_TIMING_TESTPAT_EN
  localparam int BAR_W = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;

  rgb12          rgb_q, rgb_d, pat_rgb;
  logic [CW-1:0] bar_idx;
  logic [3:0]    grey;

  always_comb begin
    bar_idx = x_d / CW'(BAR_W);
    grey    = x_d[CW-2:CW-5];
    case (pat_e'(pat_sel_i))
      PAT_BARS:    pat_rgb = (bar_idx > CW'(7)) ? RGB_BLACK : bar_colour(bar_idx[2:0]);
      PAT_CHECKER: pat_rgb = (x_d[5] ^ y_d[5]) ? RGB_WHITE : RGB_BLACK;
      PAT_RAMP:    pat_rgb = {grey, grey, grey};
      default:     pat_rgb = RGB_WHITE;
    endcase
    rgb_d = rgb_q;
    if (adv) rgb_d = video_on_d ? pat_rgb : RGB_BLACK;
  end

  always_ff @(posedge clk_50MHz or posedge rst) begin
    if (rst) rgb_q <= RGB_BLACK;
    else     rgb_q <= rgb_d;
  end

  assign rgb_o = rgb_q;
`endif

endmodule
